// File: rtl/oled_source_arbiter_pkg.sv
// Shared types and constants for the OLED source arbiter slice.
package oled_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      OWN   = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   localparam logic [15:0] BLACK  = 16'd0;
   localparam logic [15:0] GREEN  = 16'd2016;
   localparam logic [15:0] RED    = 16'd63488;
   localparam logic [15:0] YELLOW = 16'd65504;

   localparam int unsigned DEFAULT_N_SRC = 4;

endpackage

// File: rtl/oled_source_arbiter_if.sv
// Pixel-source side and OLED-driver side signals of the arbiter.
interface oled_source_arbiter_if
   import oled_arb_pkg::*;
#(
   parameter int unsigned N_SRC = DEFAULT_N_SRC
);
   logic                   frame_begin;
   logic [N_SRC-1:0]       src_req;
   logic [16*N_SRC-1:0]    src_data;
   logic [15:0]            oled_data;
   logic [N_SRC-1:0]       grant;
   logic                   busy;
   logic                   switch_pulse;

   modport master (
      output frame_begin, src_req, src_data,
      input  oled_data, grant, busy, switch_pulse
   );

   modport slave (
      input  frame_begin, src_req, src_data,
      output oled_data, grant, busy, switch_pulse
   );
endinterface

// File: rtl/oled_source_arbiter_picker.sv
// Round-robin find-first: first set request at or after ptr, wrapping mod N_SRC.
module oled_rr_picker
   import oled_arb_pkg::*;
#(
   parameter int unsigned N_SRC = DEFAULT_N_SRC,
   parameter int unsigned IDX_W = 2
)(
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);
   always_comb begin
      int unsigned pos;
      logic [IDX_W-1:0] p;
      valid = 1'b0;
      idx   = '0;
      pos   = 0;
      p     = '0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int unsigned i = 0; i < N_SRC; i++) begin
         pos = 32'(ptr) + (N_SRC - 1 - i);
         if (pos >= N_SRC) pos = pos - N_SRC;
         p = IDX_W'(pos);
         if (req[p]) begin
            valid = 1'b1;
            idx   = p;
         end
      end
   end
endmodule

// File: rtl/oled_source_arbiter.sv
// Frame-aligned round-robin owner of the OLED pixel stream across N_SRC sources.
module oled_source_arbiter
   import oled_arb_pkg::*;
#(
   parameter int unsigned N_SRC           = DEFAULT_N_SRC,
   parameter logic [15:0] IDLE_COLOUR     = BLACK,
   parameter int unsigned MIN_HOLD_FRAMES = 2,
   parameter int unsigned HOLD_W          = 4
)(
   input logic                  clock_100mhz,
   input logic                  reset_n,
   oled_source_arbiter_if.slave bus
);
   localparam int unsigned      IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_FRAMES);
   localparam logic [N_SRC-1:0] ONE      = N_SRC'(1);

   arb_state_t        state;
   logic [IDX_W-1:0]  cand, rr_ptr, cand_next, search_ptr, pick_idx;
   logic              pick_valid, cand_req;
   logic [N_SRC-1:0]  grant_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic [15:0]       oled_q, owner_pix;
   logic              busy_q, switch_q;

   always_comb begin
      cand_next  = (cand == IDX_W'(N_SRC - 1)) ? '0 : cand + 1'b1;
      // DRAIN hands over directly, searching past the current owner.
      search_ptr = (state == DRAIN) ? cand_next : rr_ptr;
      cand_req   = bus.src_req[cand];
      owner_pix  = bus.src_data[{cand, 4'b0000} +: 16];
   end

   oled_rr_picker #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_picker (
      .req   (bus.src_req),
      .ptr   (search_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cand     <= '0;
         rr_ptr   <= '0;
         grant_q  <= '0;
         hold_cnt <= '0;
         oled_q   <= IDLE_COLOUR;
         busy_q   <= 1'b0;
         switch_q <= 1'b0;
      end else begin
         switch_q <= 1'b0;
         // Select on the registered grant: the new owner shows one cycle after the switch.
         oled_q   <= (grant_q != '0) ? owner_pix : IDLE_COLOUR;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  cand   <= pick_idx;
                  state  <= ARM;
                  busy_q <= 1'b1;
               end
            end
            ARM: begin
               if (!cand_req) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (bus.frame_begin) begin
                  grant_q  <= ONE << cand;
                  hold_cnt <= '0;
                  switch_q <= 1'b1;
                  state    <= OWN;
               end
            end
            OWN: begin
               if (bus.frame_begin && (hold_cnt < HOLD_MAX))
                  hold_cnt <= hold_cnt + 1'b1;
               if (!cand_req && (hold_cnt >= HOLD_MAX))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (cand_req) begin
                  state <= OWN;
               end else if (bus.frame_begin) begin
                  rr_ptr <= cand_next;
                  if (pick_valid) begin
                     cand     <= pick_idx;
                     grant_q  <= ONE << pick_idx;
                     hold_cnt <= '0;
                     switch_q <= 1'b1;
                     state    <= OWN;
                  end else begin
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oled_data    = oled_q;
   assign bus.grant        = grant_q;
   assign bus.busy         = busy_q;
   assign bus.switch_pulse = switch_q;
endmodule

// File: tb/tb_oled_source_arbiter.sv
// Directed bench for oled_source_arbiter with hand-computed expectations.
module tb_oled_source_arbiter;
   import oled_arb_pkg::*;

   localparam logic [15:0] PIX_A = GREEN;
   localparam logic [15:0] PIX_B = RED;
   localparam logic [15:0] PIX_C = YELLOW;
   localparam logic [15:0] PIX_D = 16'h1234;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   oled_source_arbiter_if #(.N_SRC(4)) bus ();

   oled_source_arbiter #(
      .N_SRC           (4),
      .IDLE_COLOUR     (16'd0),
      .MIN_HOLD_FRAMES (2),
      .HOLD_W          (4)
   ) dut (
      .clock_100mhz (clk),
      .reset_n      (rst_n),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_frame();
      bus.frame_begin = 1'b1;
      tick(1);
      bus.frame_begin = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.frame_begin = 1'b0;
      bus.src_req     = 4'b0000;
      bus.src_data    = {PIX_D, PIX_C, PIX_B, PIX_A};
      #3;
      check("rst_oled", 32'(bus.oled_data), 32'h0);
      check("rst_grant", 32'(bus.grant), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_switch", 32'(bus.switch_pulse), 32'h0);
      #9 rst_n = 1'b1;
      tick(2);
      check("idle_busy", 32'(bus.busy), 32'h0);

      // Source B requests; grant only at frame_begin after 20 cycles.
      bus.src_req = 4'b0010;
      tick(1);
      check("arm_busy", 32'(bus.busy), 32'h1);
      check("arm_grant", 32'(bus.grant), 32'h0);
      tick(19);
      check("arm_nogrant", 32'(bus.grant), 32'h0);
      pulse_frame();
      check("b_grant", 32'(bus.grant), 32'h2);
      check("b_switch", 32'(bus.switch_pulse), 32'h1);
      check("b_oled_old", 32'(bus.oled_data), 32'h0);
      tick(1);
      check("b_oled", 32'(bus.oled_data), 32'(PIX_B));
      check("b_switch_off", 32'(bus.switch_pulse), 32'h0);

      // B drops after one frame: held until second frame, released at third.
      tick(5);
      pulse_frame();
      bus.src_req = 4'b0000;
      tick(3);
      check("hold1_grant", 32'(bus.grant), 32'h2);
      tick(5);
      pulse_frame();
      check("hold2_grant", 32'(bus.grant), 32'h2);
      tick(1);
      check("drain_grant", 32'(bus.grant), 32'h2);
      check("drain_oled", 32'(bus.oled_data), 32'(PIX_B));
      tick(5);
      pulse_frame();
      check("rel_grant", 32'(bus.grant), 32'h0);
      check("rel_busy", 32'(bus.busy), 32'h0);
      check("rel_switch", 32'(bus.switch_pulse), 32'h0);
      tick(1);
      check("rel_oled", 32'(bus.oled_data), 32'h0);

      // Candidate drops in ARM: back to IDLE, no grant at the next frame.
      bus.src_req = 4'b0001;
      tick(1);
      check("arm2_busy", 32'(bus.busy), 32'h1);
      tick(3);
      bus.src_req = 4'b0000;
      tick(1);
      check("armdrop_busy", 32'(bus.busy), 32'h0);
      pulse_frame();
      check("armdrop_grant", 32'(bus.grant), 32'h0);
      check("armdrop_switch", 32'(bus.switch_pulse), 32'h0);

      // rr_ptr is 2 here, so C is picked; reset asynchronously mid-OWN.
      bus.src_req = 4'b0100;
      tick(1);
      tick(2);
      pulse_frame();
      check("c_grant", 32'(bus.grant), 32'h4);
      tick(2);
      check("c_oled", 32'(bus.oled_data), 32'(PIX_C));
      rst_n = 1'b0;
      #1;
      check("arst_grant", 32'(bus.grant), 32'h0);
      check("arst_oled", 32'(bus.oled_data), 32'h0);
      check("arst_busy", 32'(bus.busy), 32'h0);
      check("arst_switch", 32'(bus.switch_pulse), 32'h0);
      bus.src_req = 4'b0000;
      #2 rst_n = 1'b1;
      tick(1);
      check("arst_idle", 32'(bus.busy), 32'h0);

      // Round robin with 1011: A -> B -> D -> A, handing over without a blank frame.
      bus.src_req = 4'b1011;
      tick(1);
      pulse_frame();
      check("rr_a_grant", 32'(bus.grant), 32'h1);
      check("rr_a_switch", 32'(bus.switch_pulse), 32'h1);
      tick(3);
      pulse_frame();
      tick(3);
      pulse_frame();
      bus.src_req = 4'b1010;
      tick(1);
      check("rr_a_drain", 32'(bus.grant), 32'h1);
      tick(2);
      pulse_frame();
      check("rr_b_grant", 32'(bus.grant), 32'h2);
      check("rr_b_switch", 32'(bus.switch_pulse), 32'h1);
      check("rr_ab_oled", 32'(bus.oled_data), 32'(PIX_A));
      bus.src_req = 4'b1011;
      tick(1);
      check("rr_b_oled", 32'(bus.oled_data), 32'(PIX_B));
      tick(2);
      pulse_frame();
      tick(3);
      pulse_frame();
      bus.src_req = 4'b1001;
      tick(3);
      pulse_frame();
      check("rr_d_grant", 32'(bus.grant), 32'h8);
      check("rr_bd_oled", 32'(bus.oled_data), 32'(PIX_B));
      bus.src_req = 4'b1011;
      tick(1);
      check("rr_d_oled", 32'(bus.oled_data), 32'(PIX_D));
      tick(2);
      pulse_frame();
      tick(3);
      pulse_frame();
      bus.src_req = 4'b0011;
      tick(3);
      pulse_frame();
      check("rr_a2_grant", 32'(bus.grant), 32'h1);
      check("rr_a2_switch", 32'(bus.switch_pulse), 32'h1);
      tick(1);
      check("rr_a2_oled", 32'(bus.oled_data), 32'(PIX_A));

      // Owner A reasserts in DRAIN 5 cycles before frame_begin: keeps the grant.
      tick(2);
      pulse_frame();
      tick(3);
      pulse_frame();
      bus.src_req = 4'b0010;
      tick(3);
      bus.src_req = 4'b0011;
      tick(1);
      check("reassert_switch", 32'(bus.switch_pulse), 32'h0);
      tick(4);
      pulse_frame();
      check("reassert_grant", 32'(bus.grant), 32'h1);
      check("reassert_fb_switch", 32'(bus.switch_pulse), 32'h0);

      // Reassert coinciding with frame_begin in DRAIN: owner still keeps it.
      bus.src_req = 4'b0010;
      tick(2);
      bus.src_req = 4'b0011;
      pulse_frame();
      check("same_cycle_grant", 32'(bus.grant), 32'h1);
      check("same_cycle_switch", 32'(bus.switch_pulse), 32'h0);
      tick(1);
      check("same_cycle_busy", 32'(bus.busy), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
